accel_csr_ctrl: RTL and testbench
=================================

// Module: accel_csr_ctrl
// PURPOSE
// Control/status register bank and sequencer for the lane-detection accelerator, instanced in the top level next to the weight/FIFO write decoders.
// Successor to the fixed OVALID/BUSY/RESET decode: base address and soft-reset length are parametrised.
// Adds an interrupt with enable and W1C status, frame/cycle/pixel counters, a version register and a registered read path.
// PARAMETERS
// AXI_ADDR_WIDTH   20          byte-address width of the AXI write/read ports
// CSR_BASE         395264      byte address of register 0 (word aligned)
// RESET_CYCLES     15          soft-reset low pulse length in cycles, 1..255
// PIXELS_PER_FRAME 131072      input pixel writes that make up one frame
// VERSION          32'h0002_0000  value returned by the VERSION register
// PORTS
// clk            in   1    clock
// rst_n          in   1    synchronous active-low reset
// axi_wr_data    in   32   write data
// axi_wr_addr    in   AXI_ADDR_WIDTH  write byte address
// axi_wr_strobe  in   4    write byte enables
// axi_wr_en      in   1    write strobe, one beat per cycle
// axi_rd_addr    in   AXI_ADDR_WIDTH  read byte address
// axi_rd_en      in   1    read request
// pixel_wr_en    in   1    one input pixel accepted into the input FIFO this cycle
// first_pixel    in   1    pulse: first pixel of a frame was written
// o_valid        in   1    post-process output-ready level
// csr_rd_data    out  32   registered read data
// csr_rd_hit     out  1    registered: csr_rd_data belongs to a CSR read
// internal_rst_n out  1    soft/hard reset to the datapath, active low
// busy           out  1    frame in flight
// irq            out  1    interrupt, level
// BEHAVIOUR
// Register map (byte offset from CSR_BASE). Unused offsets in 0x00-0x3C read 0 with hit=1; writes to them are ignored.
// - 0x00 OVALID      RO  bit0 = o_valid
// - 0x04 BUSY        RO  bit0 = busy
// - 0x08 RESET       WO  data[0]=1 with strobe[0] starts soft reset; reads 0
// - 0x0C IRQ_EN      RW  bit0
// - 0x10 IRQ_STATUS  W1C bit0 done event
// - 0x14 FRAME_CNT   RO  32-bit, wraps
// - 0x18 CYCLE_CNT   RO  busy cycles of the last completed frame
// - 0x1C PIXEL_CNT   RO  pixels of the current frame; bit31 = (count == PIXELS_PER_FRAME)
// - 0x20 VERSION     RO
// Reset values:
// - rst_n=0: all registers and counters are 0.
// - Outputs: csr_rd_data=0, csr_rd_hit=0, internal_rst_n=0, busy=0, irq=0.
// Soft reset:
// - A qualifying RESET write in cycle N drives internal_rst_n low for cycles N+1..N+RESET_CYCLES.
// - RESET writes are ignored while the pulse is active; the pulse is never extended.
// - Soft reset clears busy, the cycle counter, PIXEL_CNT and IRQ_STATUS. It keeps IRQ_EN, FRAME_CNT and CYCLE_CNT.
// - Write decode still operates during the pulse.
// Busy and done:
// - busy sets on first_pixel while busy=0.
// - done = o_valid rising edge (registered previous value) while busy=1.
// - On done: busy clears, FRAME_CNT+1, CYCLE_CNT latches the running cycle count, PIXEL_CNT clears, IRQ_STATUS sets.
// - first_pixel while busy=1 is ignored.
// - The running cycle counter counts while busy, saturates at 2^32-1 and restarts at 0 when busy sets.
// - PIXEL_CNT increments on pixel_wr_en while internal_rst_n=1 and saturates at 2^31-1.
// - done and pixel_wr_en in the same cycle: the clear wins.
// IRQ:
// - irq = IRQ_STATUS[0] & IRQ_EN[0], registered.
// - A done event and a W1C write in the same cycle: set wins.
// Writes:
// - Take effect on the clock edge of the axi_wr_en cycle.
// - RW fields update only when the strobe of the byte holding them is set.
// Reads:
// - One-cycle latency. A read request in cycle N gives csr_rd_data and csr_rd_hit in N+1; hit=0 when the address is outside the CSR window.
// - With no read request, csr_rd_hit=0 and csr_rd_data holds its previous value.
// - Read data samples the state before any same-cycle write.
// TESTING
// - Release rst_n, read 0x04 and 0x20 -> 0, then 32'h0002_0000 one cycle after rd_en; hit=1 both times.
// - Write 1 to 0x08 with strobe 4'b0001 -> internal_rst_n low for exactly 15 cycles; a second write at +3 cycles does not extend it.
// - Send first_pixel, 100 idle cycles, raise o_valid -> busy clears; FRAME_CNT=1; CYCLE_CNT=101 (±1 by definition); IRQ_STATUS=1; irq=0 while IRQ_EN=0.
// - Set IRQ_EN=1 -> irq=1; W1C in the same cycle as a second done -> IRQ_STATUS stays 1; a plain W1C then drops irq.
// - Send 131072 pixel_wr_en pulses -> PIXEL_CNT = 0x8002_0000; done clears it to 0.
// - Read address CSR_BASE+0x40 and address 0 -> hit=0; write IRQ_EN with strobe 4'b1110 -> value unchanged.

Source files
------------

// File: rtl/accel_csr_ctrl_if.sv
// CSR bus between the host AXI write/read decoder and the accelerator CSR bank.
// Host drives the request side; the CSR bank returns registered read data.
interface accel_csr_ctrl_if #(
    parameter int AXI_ADDR_WIDTH = 20
);
    logic [31:0]               axi_wr_data;
    logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr;
    logic [3:0]                axi_wr_strobe;
    logic                      axi_wr_en;
    logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr;
    logic                      axi_rd_en;
    logic [31:0]               csr_rd_data;
    logic                      csr_rd_hit;

    modport master (
        output axi_wr_data, axi_wr_addr, axi_wr_strobe, axi_wr_en,
        output axi_rd_addr, axi_rd_en,
        input  csr_rd_data, csr_rd_hit
    );

    modport slave (
        input  axi_wr_data, axi_wr_addr, axi_wr_strobe, axi_wr_en,
        input  axi_rd_addr, axi_rd_en,
        output csr_rd_data, csr_rd_hit
    );
endinterface

// File: rtl/accel_csr_ctrl.sv
// CSR bank and frame sequencer for the lane-detection accelerator: soft reset
// pulse, busy/done tracking, frame/cycle/pixel counters, W1C interrupt.
module accel_csr_ctrl #(
    parameter int          AXI_ADDR_WIDTH   = 20,
    parameter int          CSR_BASE         = 395264,
    parameter int          RESET_CYCLES     = 15,
    parameter int          PIXELS_PER_FRAME = 131072,
    parameter logic [31:0] VERSION          = 32'h0002_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    accel_csr_ctrl_if.slave   csr,
    input  logic              pixel_wr_en,
    input  logic              first_pixel,
    input  logic              o_valid,
    output logic              internal_rst_n,
    output logic              busy,
    output logic              irq
);
    localparam int                       AW       = AXI_ADDR_WIDTH;
    localparam logic [AW-1:0]            BASE     = AW'(CSR_BASE);
    localparam logic [AW-1:0]            WIN_SIZE = AW'(64);
    localparam logic [7:0]               RST_LEN  = 8'(RESET_CYCLES);
    localparam logic [30:0]              PIX_FULL = 31'(PIXELS_PER_FRAME);

    logic [7:0]  r_rst_cnt;
    logic        r_int_rst_n;
    logic        r_busy;
    logic        r_ov_q;
    logic [31:0] r_run_cnt;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_frame_cnt;
    logic [30:0] r_pix_cnt;
    logic        r_irq_en;
    logic        r_irq_sts;
    logic        r_irq;
    logic [31:0] r_rd_data;
    logic        r_rd_hit;

    logic [AW-1:0] w_wr_off, w_rd_off;
    logic          w_wr_in, w_rd_in;
    logic [3:0]    w_wr_idx, w_rd_idx;
    logic          w_wr_reset, w_wr_irqen, w_w1c;
    logic          w_soft, w_start, w_done, w_pix_full;
    logic [31:0]   w_run_inc;
    logic [31:0]   w_rd_val;
    logic          w_unused;

    // Offset compare rather than BASE+0x40 so a window at the top of the map cannot wrap.
    assign w_wr_off = csr.axi_wr_addr - BASE;
    assign w_rd_off = csr.axi_rd_addr - BASE;
    assign w_wr_in  = csr.axi_wr_en && (csr.axi_wr_addr >= BASE) && (w_wr_off < WIN_SIZE);
    assign w_rd_in  = (csr.axi_rd_addr >= BASE) && (w_rd_off < WIN_SIZE);
    assign w_wr_idx = w_wr_off[5:2];
    assign w_rd_idx = w_rd_off[5:2];

    assign w_wr_reset = w_wr_in && (w_wr_idx == 4'd2) && csr.axi_wr_strobe[0] && csr.axi_wr_data[0];
    assign w_wr_irqen = w_wr_in && (w_wr_idx == 4'd3) && csr.axi_wr_strobe[0];
    assign w_w1c      = w_wr_in && (w_wr_idx == 4'd4) && csr.axi_wr_strobe[0] && csr.axi_wr_data[0];

    assign w_soft     = ~r_int_rst_n;
    assign w_start    = first_pixel & ~r_busy & ~w_soft;
    assign w_done     = r_busy & o_valid & ~r_ov_q & ~w_soft;
    assign w_run_inc  = (&r_run_cnt) ? r_run_cnt : r_run_cnt + 32'd1;
    assign w_pix_full = (r_pix_cnt == PIX_FULL);
    assign w_unused   = ^{csr.axi_wr_data[31:1], csr.axi_wr_strobe[3:1]};

    always_comb begin
        w_rd_val = '0;
        case (w_rd_idx)
            4'd0:    w_rd_val = {31'd0, o_valid};
            4'd1:    w_rd_val = {31'd0, r_busy};
            4'd3:    w_rd_val = {31'd0, r_irq_en};
            4'd4:    w_rd_val = {31'd0, r_irq_sts};
            4'd5:    w_rd_val = r_frame_cnt;
            4'd6:    w_rd_val = r_cycle_cnt;
            4'd7:    w_rd_val = {w_pix_full, r_pix_cnt};
            4'd8:    w_rd_val = VERSION;
            default: w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rst_cnt   <= '0;
            r_int_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_ov_q      <= 1'b0;
            r_run_cnt   <= '0;
            r_cycle_cnt <= '0;
            r_frame_cnt <= '0;
            r_pix_cnt   <= '0;
            r_irq_en    <= 1'b0;
            r_irq_sts   <= 1'b0;
            r_irq       <= 1'b0;
            r_rd_data   <= '0;
            r_rd_hit    <= 1'b0;
        end else begin
            r_ov_q <= o_valid;

            // Non-zero r_rst_cnt means a pulse is running; new RESET writes are dropped.
            if (w_wr_reset && (r_rst_cnt == 8'd0)) begin
                r_rst_cnt   <= RST_LEN;
                r_int_rst_n <= 1'b0;
            end else if (r_rst_cnt != 8'd0) begin
                r_rst_cnt   <= r_rst_cnt - 8'd1;
                r_int_rst_n <= (r_rst_cnt == 8'd1);
            end else begin
                r_int_rst_n <= 1'b1;
            end

            if (w_soft) begin
                r_busy    <= 1'b0;
                r_run_cnt <= '0;
                r_pix_cnt <= '0;
                r_irq_sts <= 1'b0;
            end else begin
                if (w_start) begin
                    r_busy    <= 1'b1;
                    r_run_cnt <= '0;
                end else if (w_done) begin
                    r_busy      <= 1'b0;
                    r_frame_cnt <= r_frame_cnt + 32'd1;
                    r_cycle_cnt <= w_run_inc;
                end else if (r_busy) begin
                    r_run_cnt <= w_run_inc;
                end

                if (w_done)
                    r_pix_cnt <= '0;
                else if (pixel_wr_en && !(&r_pix_cnt))
                    r_pix_cnt <= r_pix_cnt + 31'd1;

                if (w_done)
                    r_irq_sts <= 1'b1;
                else if (w_w1c)
                    r_irq_sts <= 1'b0;
            end

            if (w_wr_irqen)
                r_irq_en <= csr.axi_wr_data[0];

            r_irq    <= r_irq_sts & r_irq_en;
            r_rd_hit <= csr.axi_rd_en & w_rd_in;
            if (csr.axi_rd_en)
                r_rd_data <= w_rd_in ? w_rd_val : 32'd0;
        end
    end

    assign internal_rst_n  = r_int_rst_n;
    assign busy            = r_busy;
    assign irq             = r_irq;
    assign csr.csr_rd_data = r_rd_data;
    assign csr.csr_rd_hit  = r_rd_hit;
endmodule

// File: tb/tb_accel_csr_ctrl.sv
// Directed bench for accel_csr_ctrl: register-read table plus hand sequences
// for soft reset, frame done, W1C/IRQ races and pixel counting.
module tb_accel_csr_ctrl;
    localparam int          AW   = 20;
    localparam logic [19:0] BASE = 20'h60800;
    localparam int          PPF  = 256;
    localparam logic [31:0] VER  = 32'h0002_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pixel_wr_en = 1'b0;
    logic first_pixel = 1'b0;
    logic o_valid = 1'b0;
    logic internal_rst_n, busy, irq;

    int total = 0;
    int bad = 0;

    accel_csr_ctrl_if #(.AXI_ADDR_WIDTH(AW)) bus ();

    accel_csr_ctrl #(
        .AXI_ADDR_WIDTH(AW),
        .CSR_BASE(395264),
        .RESET_CYCLES(15),
        .PIXELS_PER_FRAME(PPF),
        .VERSION(VER)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .csr(bus),
        .pixel_wr_en(pixel_wr_en),
        .first_pixel(first_pixel),
        .o_valid(o_valid),
        .internal_rst_n(internal_rst_n),
        .busy(busy),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] addr;
        logic        hit;
        logic        chk_data;
        logic [31:0] data;
    } rvec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // All driving and sampling happens at negedge; the DUT samples on posedge.
    task automatic wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb);
        bus.axi_wr_addr   = BASE + 20'(off);
        bus.axi_wr_data   = data;
        bus.axi_wr_strobe = strb;
        bus.axi_wr_en     = 1'b1;
        @(negedge clk);
        bus.axi_wr_en     = 1'b0;
    endtask

    task automatic rd(input logic [19:0] addr, output logic [31:0] d, output logic h);
        bus.axi_rd_addr = addr;
        bus.axi_rd_en   = 1'b1;
        @(negedge clk);
        d = bus.csr_rd_data;
        h = bus.csr_rd_hit;
        bus.axi_rd_en   = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] d;
        logic h;
        rd(BASE + 20'(off), d, h);
        chk({name, "_hit"}, {31'd0, h}, 32'd1);
        chk(name, d, exp);
    endtask

    initial begin
        rvec_t tab[13];
        logic [31:0] d;
        logic h;
        int low;

        bus.axi_wr_data = '0; bus.axi_wr_addr = '0; bus.axi_wr_strobe = '0;
        bus.axi_wr_en = 1'b0; bus.axi_rd_addr = '0; bus.axi_rd_en = 1'b0;

        tab[0]  = '{BASE + 20'h00, 1'b1, 1'b1, 32'd0};
        tab[1]  = '{BASE + 20'h04, 1'b1, 1'b1, 32'd0};
        tab[2]  = '{BASE + 20'h08, 1'b1, 1'b1, 32'd0};
        tab[3]  = '{BASE + 20'h0C, 1'b1, 1'b1, 32'd0};
        tab[4]  = '{BASE + 20'h10, 1'b1, 1'b1, 32'd0};
        tab[5]  = '{BASE + 20'h14, 1'b1, 1'b1, 32'd0};
        tab[6]  = '{BASE + 20'h18, 1'b1, 1'b1, 32'd0};
        tab[7]  = '{BASE + 20'h1C, 1'b1, 1'b1, 32'd0};
        tab[8]  = '{BASE + 20'h24, 1'b1, 1'b1, 32'd0};
        tab[9]  = '{BASE + 20'h3C, 1'b1, 1'b1, 32'd0};
        tab[10] = '{BASE + 20'h40, 1'b0, 1'b0, 32'd0};
        tab[11] = '{20'h00000,     1'b0, 1'b0, 32'd0};
        tab[12] = '{BASE + 20'h20, 1'b1, 1'b1, VER};

        // Hard reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_data", bus.csr_rd_data, 32'd0);
        chk("rst_rd_hit", {31'd0, bus.csr_rd_hit}, 32'd0);
        chk("rst_int_rst_n", {31'd0, internal_rst_n}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("int_rst_n_released", {31'd0, internal_rst_n}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            rd(tab[i].addr, d, h);
            chk($sformatf("hit@%h", tab[i].addr), {31'd0, h}, {31'd0, tab[i].hit});
            if (tab[i].chk_data)
                chk($sformatf("data@%h", tab[i].addr), d, tab[i].data);
        end
        // Last table entry read VERSION; idle cycle holds data and drops hit
        @(negedge clk);
        chk("idle_hit", {31'd0, bus.csr_rd_hit}, 32'd0);
        chk("idle_hold", bus.csr_rd_data, VER);

        // Soft reset: 15 low cycles, second write at +3 ignored
        wr(8'h08, 32'd1, 4'b0001);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            if (!internal_rst_n) low++;
            if (i == 2) begin
                bus.axi_wr_addr = BASE + 20'h08; bus.axi_wr_data = 32'd1;
                bus.axi_wr_strobe = 4'b0001; bus.axi_wr_en = 1'b1;
            end else begin
                bus.axi_wr_en = 1'b0;
            end
            @(negedge clk);
        end
        chk("soft_rst_len", low, 32'd15);

        // Frame 1: 100 idle cycles, a stray first_pixel while busy is ignored
        first_pixel = 1'b1;
        @(negedge clk);
        first_pixel = 1'b0;
        chk("busy_set", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 100; i++) begin
            first_pixel = (i == 49);
            @(negedge clk);
        end
        first_pixel = 1'b0;
        o_valid = 1'b1;
        @(negedge clk);
        chk("busy_clr", {31'd0, busy}, 32'd0);
        rd_chk("frame1", 8'h14, 32'd1);
        rd_chk("cycle1", 8'h18, 32'd101);
        rd_chk("sts1", 8'h10, 32'd1);
        rd_chk("ovalid", 8'h00, 32'd1);
        chk("irq_masked", {31'd0, irq}, 32'd0);

        // Enable IRQ; irq follows one cycle after the register
        wr(8'h0C, 32'd1, 4'b0001);
        @(negedge clk);
        chk("irq_on", {31'd0, irq}, 32'd1);

        // Frame 2: done and W1C in the same cycle, set wins
        o_valid = 1'b0;
        first_pixel = 1'b1;
        @(negedge clk);
        first_pixel = 1'b0;
        repeat (5) @(negedge clk);
        o_valid = 1'b1;
        wr(8'h10, 32'd1, 4'b0001);
        rd_chk("sts_race", 8'h10, 32'd1);
        rd_chk("frame2", 8'h14, 32'd2);
        chk("irq_race", {31'd0, irq}, 32'd1);
        wr(8'h10, 32'd1, 4'b0001);
        repeat (2) @(negedge clk);
        chk("irq_w1c", {31'd0, irq}, 32'd0);
        rd_chk("sts_w1c", 8'h10, 32'd0);

        // Strobe gating on RW and WO fields
        wr(8'h0C, 32'd0, 4'b1110);
        rd_chk("irqen_strb", 8'h0C, 32'd1);
        wr(8'h08, 32'd1, 4'b1110);
        @(negedge clk);
        chk("reset_strb", {31'd0, internal_rst_n}, 32'd1);

        // Pixels: full frame flag, then one past
        o_valid = 1'b0;
        pixel_wr_en = 1'b1;
        repeat (PPF) @(negedge clk);
        pixel_wr_en = 1'b0;
        rd_chk("pix_full", 8'h1C, 32'h8000_0100);
        pixel_wr_en = 1'b1;
        @(negedge clk);
        pixel_wr_en = 1'b0;
        rd_chk("pix_over", 8'h1C, 32'h0000_0101);

        // Frame 3: done with pixel_wr_en in the same cycle clears the count
        first_pixel = 1'b1;
        @(negedge clk);
        first_pixel = 1'b0;
        repeat (3) @(negedge clk);
        o_valid = 1'b1;
        pixel_wr_en = 1'b1;
        @(negedge clk);
        pixel_wr_en = 1'b0;
        rd_chk("pix_done_clr", 8'h1C, 32'd0);
        rd_chk("frame3", 8'h14, 32'd3);
        rd_chk("cycle3", 8'h18, 32'd4);

        // Soft reset clears PIXEL_CNT/IRQ_STATUS, keeps IRQ_EN/FRAME/CYCLE
        pixel_wr_en = 1'b1;
        repeat (5) @(negedge clk);
        pixel_wr_en = 1'b0;
        rd_chk("pix_pre_soft", 8'h1C, 32'd5);
        wr(8'h08, 32'd1, 4'b0001);
        repeat (20) @(negedge clk);
        rd_chk("soft_pix", 8'h1C, 32'd0);
        rd_chk("soft_sts", 8'h10, 32'd0);
        rd_chk("soft_irqen", 8'h0C, 32'd1);
        rd_chk("soft_frame", 8'h14, 32'd3);
        rd_chk("soft_cycle", 8'h18, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
